// File: rtl/bcd_tens_comp_alu.sv
// Digit-serial ten's-complement BCD adder/subtractor: one decimal digit per clock,
// LSD first, with start/busy/done handshake and overflow/invalid status.
module bcd_tens_comp_alu #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4*DIGITS-1:0] din,
  input  logic                load_a,
  input  logic                load_b,
  input  logic                start,
  input  logic                op,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] result,
  output logic                cout,
  output logic                ovf,
  output logic                invalid
);

  localparam int unsigned   IW   = (DIGITS > 2) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              r_state, w_next;
  logic [4*DIGITS-1:0] r_a, r_b, r_res;
  logic [IW-1:0]       r_idx;
  logic                r_op, r_carry, r_inv_pend;
  logic                r_done, r_cout, r_ovf, r_invalid;

  logic       w_accept, w_last, w_inv_now, w_cy, w_ovf;
  logic       w_sa, w_sb, w_sr;
  logic [3:0] w_ad, w_bd, w_bp, w_dig, w_dig_wr;
  logic [4:0] w_s;

  assign w_accept = (r_state == IDLE) && start;
  assign w_last   = (r_state == RUN) && (r_idx == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (r_idx == LAST) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_ad      = '0;
    w_bd      = '0;
    w_inv_now = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (IW'(i) == r_idx) begin
        w_ad = r_a[4*i +: 4];
        w_bd = r_b[4*i +: 4];
      end
      if (r_a[4*i +: 4] > 4'd9 || r_b[4*i +: 4] > 4'd9) w_inv_now = 1'b1;
    end
  end

  assign w_bp     = r_op ? (4'd9 - w_bd) : w_bd;
  assign w_s      = {1'b0, w_ad} + {1'b0, w_bp} + {4'b0, r_carry};
  assign w_cy     = (w_s > 5'd9);
  assign w_dig    = w_cy ? 4'(w_s - 5'd10) : w_s[3:0];
  // Invalid operands write zero digits so out-of-range sums never reach result.
  assign w_dig_wr = r_inv_pend ? 4'd0 : w_dig;

  // Result sign comes from the MSD being computed in the final cycle.
  assign w_sa  = (r_a[4*DIGITS-1 -: 4] > 4'd4);
  assign w_sb  = (r_b[4*DIGITS-1 -: 4] > 4'd4);
  assign w_sr  = (w_dig > 4'd4);
  assign w_ovf = r_op ? ((w_sa != w_sb) && (w_sr != w_sa))
                      : ((w_sa == w_sb) && (w_sr != w_sa));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a        <= '0;
      r_b        <= '0;
      r_res      <= '0;
      r_idx      <= '0;
      r_op       <= 1'b0;
      r_carry    <= 1'b0;
      r_inv_pend <= 1'b0;
      r_done     <= 1'b0;
      r_cout     <= 1'b0;
      r_ovf      <= 1'b0;
      r_invalid  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_op       <= op;
        r_carry    <= op;
        r_idx      <= '0;
        r_res      <= '0;
        r_invalid  <= 1'b0;
        r_inv_pend <= w_inv_now;
      end else if (r_state == IDLE) begin
        if (load_a) r_a <= din;
        if (load_b) r_b <= din;
      end else begin
        for (int unsigned i = 0; i < DIGITS; i++) begin
          if (IW'(i) == r_idx) r_res[4*i +: 4] <= w_dig_wr;
        end
        r_carry <= w_cy;
        r_idx   <= r_idx + IW'(1);
        if (w_last) begin
          r_idx     <= '0;
          r_done    <= 1'b1;
          r_cout    <= r_inv_pend ? 1'b0 : w_cy;
          r_ovf     <= r_inv_pend ? 1'b0 : w_ovf;
          r_invalid <= r_inv_pend;
        end
      end
    end
  end

  assign busy    = (r_state == RUN);
  assign done    = r_done;
  assign result  = r_res;
  assign cout    = r_cout;
  assign ovf     = r_ovf;
  assign invalid = r_invalid;

endmodule

// File: tb/tb_bcd_tens_comp_alu.sv
// Scoreboard bench for bcd_tens_comp_alu: DIGITS=4 and DIGITS=8 instances,
// expectations from an integer ten's-complement model.
module tb_bcd_tens_comp_alu;

  typedef struct {
    logic [31:0] res;
    logic        cout;
    logic        ovf;
    logic        inv;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_tot = 0;
  int   n_bad = 0;
  exp_t q4[$];
  exp_t q8[$];

  logic [15:0] din4 = '0, res4, ma4 = '0, mb4 = '0;
  logic        la4 = 0, lb4 = 0, st4 = 0, op4 = 0;
  logic        busy4, done4, cout4, ovf4, inv4, prev_done4 = 0;
  logic [31:0] din8 = '0, res8, ma8 = '0, mb8 = '0;
  logic        la8 = 0, lb8 = 0, st8 = 0, op8 = 0;
  logic        busy8, done8, cout8, ovf8, inv8;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bcd_tens_comp_alu #(.DIGITS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .din(din4), .load_a(la4), .load_b(lb4),
    .start(st4), .op(op4), .busy(busy4), .done(done4), .result(res4),
    .cout(cout4), .ovf(ovf4), .invalid(inv4));

  bcd_tens_comp_alu #(.DIGITS(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .din(din8), .load_a(la8), .load_b(lb8),
    .start(st8), .op(op8), .busy(busy8), .done(done8), .result(res8),
    .cout(cout8), .ovf(ovf8), .invalid(inv8));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic o, input int d);
    exp_t e;
    longint pw, va, vb, s;
    logic bad, sa, sb, sr;
    logic [3:0] n;
    pw = 1; va = 0; vb = 0; bad = 0;
    for (int i = d - 1; i >= 0; i--) begin
      pw = pw * 10;
      n = a[4*i +: 4]; bad |= (n > 9); va = va * 10 + longint'(n);
      n = b[4*i +: 4]; bad |= (n > 9); vb = vb * 10 + longint'(n);
    end
    s = o ? (va + pw - vb) : (va + vb);
    e.cout = (s >= pw);
    s = s % pw;
    e.res = '0;
    for (int i = 0; i < d; i++) begin
      e.res[4*i +: 4] = 4'(s % 10);
      s = s / 10;
    end
    sa = (a[4*(d-1) +: 4] > 4);
    sb = (b[4*(d-1) +: 4] > 4);
    sr = (e.res[4*(d-1) +: 4] > 4);
    e.ovf = o ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
    if (bad) begin
      e.res = '0; e.cout = 0; e.ovf = 0;
    end
    e.inv = bad;
    e.cyc = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (busy4 && done4) check("busy_done4", 1, 0);
      if (prev_done4) check("done_pulse4", done4, 0);
      prev_done4 = done4;
      if (done4) begin
        if (q4.size() == 0) check("spurious_done4", 1, 0);
        else begin
          e = q4.pop_front();
          check("result4", res4, e.res);
          check("cout4", cout4, e.cout);
          check("ovf4", ovf4, e.ovf);
          check("invalid4", inv4, e.inv);
          check("latency4", cyc - e.cyc, 4);
        end
      end
      if (busy8 && done8) check("busy_done8", 1, 0);
      if (done8) begin
        if (q8.size() == 0) check("spurious_done8", 1, 0);
        else begin
          e = q8.pop_front();
          check("result8", res8, e.res);
          check("cout8", cout8, e.cout);
          check("ovf8", ovf8, e.ovf);
          check("invalid8", inv8, e.inv);
          check("latency8", cyc - e.cyc, 8);
        end
      end
    end
  end

  task automatic load4(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk); din4 = a; la4 = 1;
    @(negedge clk); din4 = b; la4 = 0; lb4 = 1;
    @(negedge clk); lb4 = 0;
    ma4 = a; mb4 = b;
  endtask

  task automatic start4(input logic o, input logic with_load, input logic [15:0] d);
    exp_t e;
    @(negedge clk);
    st4 = 1; op4 = o; la4 = with_load; din4 = d;
    e = model({16'h0, ma4}, {16'h0, mb4}, o, 4);
    e.cyc = cyc + 1;
    q4.push_back(e);
    @(negedge clk);
    st4 = 0; la4 = 0;
  endtask

  task automatic wait4();
    for (int i = 0; i < 20 && q4.size() != 0; i++) @(negedge clk);
    if (q4.size() != 0) begin
      check("timeout4", q4.size(), 0);
      q4.delete();
    end
  endtask

  task automatic run4(input logic [15:0] a, input logic [15:0] b, input logic o);
    load4(a, b);
    start4(o, 0, 16'h0);
    wait4();
  endtask

  task automatic run8(input logic [31:0] a, input logic [31:0] b, input logic o);
    exp_t e;
    @(negedge clk); din8 = a; la8 = 1;
    @(negedge clk); din8 = b; la8 = 0; lb8 = 1;
    @(negedge clk); lb8 = 0; st8 = 1; op8 = o;
    e = model(a, b, o, 8);
    e.cyc = cyc + 1;
    q8.push_back(e);
    @(negedge clk); st8 = 0;
    for (int i = 0; i < 30 && q8.size() != 0; i++) @(negedge clk);
    if (q8.size() != 0) begin
      check("timeout8", q8.size(), 0);
      q8.delete();
    end
  endtask

  initial begin
    #12;
    check("rst_busy", busy4, 0);
    check("rst_done", done4, 0);
    check("rst_result", res4, 0);
    check("rst_flags", {cout4, ovf4, inv4}, 0);
    @(negedge clk); rst_n = 1;

    run4(16'h0123, 16'h0456, 0);
    run4(16'h0100, 16'h0250, 1);
    run4(16'h0250, 16'h0100, 1);
    run4(16'h4999, 16'h0001, 0);
    run4(16'h5000, 16'h0001, 1);
    run4(16'h9999, 16'h0001, 0);
    run4(16'h00A1, 16'h0001, 0);
    run4(16'h0007, 16'h0008, 0);

    // back-to-back: second start lands on the done cycle
    load4(16'h0123, 16'h0456);
    start4(0, 0, 16'h0);
    repeat (3) @(negedge clk);
    start4(1, 0, 16'h0);
    wait4();

    // start with load_a together: old A used and kept
    load4(16'h0011, 16'h0022);
    start4(0, 1, 16'h0999);
    wait4();
    start4(0, 0, 16'h0);
    wait4();

    // start/loads while busy are ignored
    load4(16'h0123, 16'h0456);
    start4(0, 0, 16'h0);
    st4 = 1; la4 = 1; lb4 = 1; op4 = 1; din4 = 16'h9999;
    repeat (2) @(negedge clk);
    st4 = 0; la4 = 0; lb4 = 0;
    wait4();
    start4(0, 0, 16'h0);
    wait4();

    // reset mid-run: no done, back to reset values
    load4(16'h0123, 16'h0456);
    start4(0, 0, 16'h0);
    @(negedge clk);
    rst_n = 0;
    q4.delete();
    #1;
    check("midrst_busy", busy4, 0);
    check("midrst_result", res4, 0);
    check("midrst_done", done4, 0);
    @(negedge clk); rst_n = 1;
    ma4 = '0; mb4 = '0; ma8 = '0; mb8 = '0;
    repeat (8) @(negedge clk);
    start4(0, 0, 16'h0);
    wait4();
    run4(16'h0123, 16'h0456, 0);

    run8(32'h49999999, 32'h00000001, 0);
    run8(32'h12345678, 32'h87654321, 1);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
